// File: rtl/vga_display_ctrl.sv
// VGA display controller for the 640x480@60 Hz game pages.
// Generates raster timing, presents x_pos/y_pos to the page renderers,
// and re-aligns sync/blanking with the renderer's pipelined pixel so that
// hs/vs/r/g/b leave this block registered and mutually aligned.
module vga_display_ctrl #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned PIXEL_LAT   = 1,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic        vga_clk,
    input  logic        vga_rst,
    input  logic [11:0] pixel_data,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        video_on,
    output logic        frame_start,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 10-bit copies of the timing points so every compare is width-matched
    localparam logic [9:0] H_LAST_C   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST_C   = 10'(V_TOT - 1);
    localparam logic [9:0] H_ACT_C    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST_C = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST_C  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST_C = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST_C  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Raster counters
    logic [9:0] h_cnt_r;
    logic [9:0] v_cnt_r;
    logic [9:0] h_nxt_s;
    logic [9:0] v_nxt_s;

    // Counter decode feeding stage 1
    logic       h_vis_s;
    logic       v_vis_s;
    logic       hs_act_s;
    logic       vs_act_s;

    // Stage 1 registers (renderer-facing)
    logic [9:0] x_pos_r;
    logic [9:0] y_pos_r;
    logic       video_on_r;
    logic       frame_start_r;
    logic       hs_s1_r;
    logic       vs_s1_r;

    // Delay line matching the renderer latency; bit 0 is the first stage
    logic [PIXEL_LAT-1:0] von_dly_r;
    logic [PIXEL_LAT-1:0] hs_dly_r;
    logic [PIXEL_LAT-1:0] vs_dly_r;

    // Connector-facing output registers
    logic       hs_r;
    logic       vs_r;
    logic [3:0] r_r;
    logic [3:0] g_r;
    logic [3:0] b_r;

    // Next-state of the counters: line wrap bumps the line count, frame wrap clears both together
    always_comb begin
        h_nxt_s = h_cnt_r;
        v_nxt_s = v_cnt_r;
        if (h_cnt_r == H_LAST_C) begin
            h_nxt_s = 10'd0;
            if (v_cnt_r == V_LAST_C) begin
                v_nxt_s = 10'd0;
            end else begin
                v_nxt_s = v_cnt_r + 10'd1;
            end
        end else begin
            h_nxt_s = h_cnt_r + 10'd1;
            v_nxt_s = v_cnt_r;
        end
    end

    // Counter register
    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
        end else begin
            h_cnt_r <= h_nxt_s;
            v_cnt_r <= v_nxt_s;
        end
    end

    // Region decode of the current counter values
    always_comb begin
        h_vis_s  = (h_cnt_r < H_ACT_C);
        v_vis_s  = (v_cnt_r < V_ACT_C);
        hs_act_s = (h_cnt_r >= HS_FIRST_C) && (h_cnt_r <= HS_LAST_C);
        vs_act_s = (v_cnt_r >= VS_FIRST_C) && (v_cnt_r <= VS_LAST_C);
    end

    // Stage 1: registered position, visibility, frame marker and raw sync flags
    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            x_pos_r       <= 10'd0;
            y_pos_r       <= 10'd0;
            video_on_r    <= 1'b0;
            frame_start_r <= 1'b0;
            hs_s1_r       <= 1'b0;
            vs_s1_r       <= 1'b0;
        end else begin
            x_pos_r       <= h_vis_s ? h_cnt_r : 10'd0;
            y_pos_r       <= v_vis_s ? v_cnt_r : 10'd0;
            video_on_r    <= h_vis_s && v_vis_s;
            frame_start_r <= (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
            hs_s1_r       <= hs_act_s;
            vs_s1_r       <= vs_act_s;
        end
    end

    // Delay line: blanking and sync flags follow the renderer pipeline in lockstep
    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            von_dly_r <= '0;
            hs_dly_r  <= '0;
            vs_dly_r  <= '0;
        end else begin
            von_dly_r[0] <= video_on_r;
            hs_dly_r[0]  <= hs_s1_r;
            vs_dly_r[0]  <= vs_s1_r;
            for (int i = 1; i < int'(PIXEL_LAT); i++) begin
                von_dly_r[i] <= von_dly_r[i-1];
                hs_dly_r[i]  <= hs_dly_r[i-1];
                vs_dly_r[i]  <= vs_dly_r[i-1];
            end
        end
    end

    // Output register: blank colour outside the visible area, drive sync at its asserted level
    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            hs_r <= ~SYNC_ACTIVE;
            vs_r <= ~SYNC_ACTIVE;
            r_r  <= 4'd0;
            g_r  <= 4'd0;
            b_r  <= 4'd0;
        end else begin
            hs_r <= hs_dly_r[PIXEL_LAT-1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vs_r <= vs_dly_r[PIXEL_LAT-1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            if (von_dly_r[PIXEL_LAT-1]) begin
                r_r <= pixel_data[3:0];
                g_r <= pixel_data[7:4];
                b_r <= pixel_data[11:8];
            end else begin
                r_r <= 4'd0;
                g_r <= 4'd0;
                b_r <= 4'd0;
            end
        end
    end

    assign x_pos       = x_pos_r;
    assign y_pos       = y_pos_r;
    assign video_on    = video_on_r;
    assign frame_start = frame_start_r;
    assign hs          = hs_r;
    assign vs          = vs_r;
    assign r           = r_r;
    assign g           = g_r;
    assign b           = b_r;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Directed bench for vga_display_ctrl.
// dut1: full 640x480 timing, PIXEL_LAT=1, renderer emits a position pattern on
//       lines 0..1 and 12'hfff from line 2 on.
// dut3: shrunken timing (25x15 raster) with PIXEL_LAT=3 so whole frames,
//       vsync and frame wrap fit in a short run.
// Expected values come from a linear-count raster model in the bench.
module tb_vga_display_ctrl;

    logic vga_clk = 1'b0;
    logic vga_rst;

    always #5 vga_clk = ~vga_clk;

    int tests = 0;
    int fails = 0;

    // dut1 signals
    logic [11:0] pd1;
    logic [9:0]  x1, y1;
    logic        von1, fs1, hs1, vs1;
    logic [3:0]  r1, g1, b1;

    // dut3 signals
    logic [11:0] pd3, pd3_s0, pd3_s1;
    logic [9:0]  x3, y3;
    logic        von3, fs3, hs3, vs3;
    logic [3:0]  r3, g3, b3;

    vga_display_ctrl dut1 (
        .vga_clk     (vga_clk),
        .vga_rst     (vga_rst),
        .pixel_data  (pd1),
        .x_pos       (x1),
        .y_pos       (y1),
        .video_on    (von1),
        .frame_start (fs1),
        .hs          (hs1),
        .vs          (vs1),
        .r           (r1),
        .g           (g1),
        .b           (b1)
    );

    vga_display_ctrl #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
        .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3),
        .PIXEL_LAT (3), .SYNC_ACTIVE (1'b0)
    ) dut3 (
        .vga_clk     (vga_clk),
        .vga_rst     (vga_rst),
        .pixel_data  (pd3),
        .x_pos       (x3),
        .y_pos       (y3),
        .video_on    (von3),
        .frame_start (fs3),
        .hs          (hs3),
        .vs          (vs3),
        .r           (r3),
        .g           (g3),
        .b           (b3)
    );

    // Renderer stand-in for dut1: one-clock latency
    always @(posedge vga_clk) begin
        pd1 <= (y1 >= 10'd2) ? 12'hfff : {2'b00, y1[4:0], x1[4:0]};
    end

    // Renderer stand-in for dut3: three-clock latency
    always @(posedge vga_clk) begin
        pd3_s0 <= {2'b00, y3[4:0], x3[4:0]};
        pd3_s1 <= pd3_s0;
        pd3    <= pd3_s1;
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // k = clock edges since reset release (0 = in reset). Stage-1 outputs show
    // raster position n=k-1; connector outputs show position n-(p+1).
    task automatic check_all(input string id, input int k,
                             input int ha, input int hf, input int hsw, input int hb,
                             input int va, input int vf, input int vsw, input int vb,
                             input int p, input bit fff_from2,
                             input logic [9:0] ox, input logic [9:0] oy,
                             input logic ovon, input logic ofs,
                             input logic ohs, input logic ovs, input logic [11:0] orgb);
        int ht, vt, n, h, v, m, hm, vm;
        int ex, ey, evon, efs, ehs, evs, ergb;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        n  = k - 1;
        ex = 0; ey = 0; evon = 0; efs = 0;
        ehs = 1; evs = 1; ergb = 0;
        if (k > 0) begin
            h    = n % ht;
            v    = (n / ht) % vt;
            ex   = (h < ha) ? h : 0;
            ey   = (v < va) ? v : 0;
            evon = (h < ha && v < va) ? 1 : 0;
            efs  = (h == 0 && v == 0) ? 1 : 0;
            m    = n - (p + 1);
            if (m >= 0) begin
                hm  = m % ht;
                vm  = (m / ht) % vt;
                ehs = (hm >= ha + hf && hm < ha + hf + hsw) ? 0 : 1;
                evs = (vm >= va + vf && vm < va + vf + vsw) ? 0 : 1;
                if (hm < ha && vm < va) begin
                    if (fff_from2 && vm >= 2) ergb = 32'hfff;
                    else ergb = ((vm % 32) * 32) + (hm % 32);
                end else begin
                    ergb = 0;
                end
            end
        end
        chk({id, ".x_pos"},       k, 32'(ox),   32'(ex));
        chk({id, ".y_pos"},       k, 32'(oy),   32'(ey));
        chk({id, ".video_on"},    k, 32'(ovon), 32'(evon));
        chk({id, ".frame_start"}, k, 32'(ofs),  32'(efs));
        chk({id, ".hs"},          k, 32'(ohs),  32'(ehs));
        chk({id, ".vs"},          k, 32'(ovs),  32'(evs));
        chk({id, ".rgb"},         k, 32'(orgb), 32'(ergb));
    endtask

    task automatic check_both(input int k);
        check_all("d1", k, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b1,
                  x1, y1, von1, fs1, hs1, vs1, {b1, g1, r1});
        check_all("d3", k, 16, 2, 4, 3, 8, 2, 2, 3, 3, 1'b0,
                  x3, y3, von3, fs3, hs3, vs3, {b3, g3, r3});
    endtask

    initial begin
        vga_rst = 1'b1;

        // Step 1: reset held for 10 clocks, outputs at reset values throughout
        repeat (10) begin
            @(posedge vga_clk);
            @(negedge vga_clk);
            check_both(0);
        end

        // Step 2: release and run; dut1 covers 4+ lines (pattern then 12'hfff),
        // dut3 covers several complete frames including vsync and frame wrap
        vga_rst = 1'b0;
        for (int k = 1; k <= 3501; k++) begin
            @(posedge vga_clk);
            @(negedge vga_clk);
            check_both(k);
        end

        // Step 3: asynchronous reset mid-frame (dut1 at line 4, column 300),
        // outputs must clear before the next clock edge
        #2;
        vga_rst = 1'b1;
        #1;
        check_both(0);
        repeat (3) begin
            @(posedge vga_clk);
            @(negedge vga_clk);
            check_both(0);
        end

        // Step 4: release again; frame_start on the first edge, clean restart
        vga_rst = 1'b0;
        for (int k = 1; k <= 900; k++) begin
            @(posedge vga_clk);
            @(negedge vga_clk);
            check_both(k);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
